// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//
// Purpose:
//   Forwarding-select and hazard-detection unit for a pipelined core. It
//   produces EX operand and ID branch-comparator forwarding selectors. It
//   raises a stall for load-use, branch-compare and long-latency hazards,
//   and keeps a per-register scoreboard of pending long-latency writes.
//
// Ports:
//   iCLK, iRST                       clock, asynchronous active-high reset
//   iID_NumRs/iID_NumRt, iID_Branch  ID source registers and branch flag
//   iEX_NumRs/iEX_NumRt              EX source registers
//   iEX_NumRd/RegWrite/MemRead       EX destination, write-enable, load flag
//   iSrc_NumRd, iSrc_We              flattened forwarding-source dests/enables
//                                    (source 0 = MEM is youngest, 1 = WB)
//   iIssue_Valid/Rd/Lat              long-latency issue request
//   oFwdA/oFwdB                      EX operand selectors (0 = regfile, k+1 = src k)
//   oFwdBranchRs/oFwdBranchRt        ID branch selectors, same encoding
//   oStall                           hold PC/IFID, bubble IDEX
//   oBusy                            some long-latency write is pending
//   oStallCount                      stall-cycle counter
//
// Optional feature:
//   FWD_STALLCNT_EN  when defined, oStallCount counts stalled cycles;
//                    otherwise it is tied to zero and no register exists.
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int NSRC = 2,
    parameter int REGW = 5,
    parameter int LATW = 4,
    localparam int SELW = $clog2(NSRC + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [REGW-1:0]      iID_NumRs,
    input  logic [REGW-1:0]      iID_NumRt,
    input  logic                 iID_Branch,
    input  logic [REGW-1:0]      iEX_NumRs,
    input  logic [REGW-1:0]      iEX_NumRt,
    input  logic [REGW-1:0]      iEX_NumRd,
    input  logic                 iEX_RegWrite,
    input  logic                 iEX_MemRead,
    input  logic [NSRC*REGW-1:0] iSrc_NumRd,
    input  logic [NSRC-1:0]      iSrc_We,
    input  logic                 iIssue_Valid,
    input  logic [REGW-1:0]      iIssue_Rd,
    input  logic [LATW-1:0]      iIssue_Lat,
    output logic [SELW-1:0]      oFwdA,
    output logic [SELW-1:0]      oFwdB,
    output logic [SELW-1:0]      oFwdBranchRs,
    output logic [SELW-1:0]      oFwdBranchRt,
    output logic                 oStall,
    output logic                 oBusy,
    output logic [31:0]          oStallCount
);

    localparam int NREG = 2 ** REGW;

    logic [LATW-1:0] lat_cnt [NREG];
    logic [NREG-1:0] pending;
    logic            load_use_stall;
    logic            branch_stall;
    logic            raw_stall;
    logic            waw_stall;
    logic            issue_accept;

    // Selector for one operand. The scan runs from the oldest source down to
    // the youngest, so the youngest matching source wins. Register 0 is
    // hard-wired to zero and is never forwarded.
    function automatic logic [SELW-1:0] fwd_sel(
        input logic [REGW-1:0]      reg_num,
        input logic [NSRC*REGW-1:0] src_rd,
        input logic [NSRC-1:0]      src_we
    );
        logic [SELW-1:0] sel;
        sel = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (src_we[k] && (src_rd[k*REGW +: REGW] == reg_num) && (reg_num != '0)) begin
                sel = SELW'(k + 1);
            end
        end
        return sel;
    endfunction

    // All four forwarding selectors are purely combinational and share one rule.
    always_comb begin
        oFwdA        = fwd_sel(iEX_NumRs, iSrc_NumRd, iSrc_We);
        oFwdB        = fwd_sel(iEX_NumRt, iSrc_NumRd, iSrc_We);
        oFwdBranchRs = fwd_sel(iID_NumRs, iSrc_NumRd, iSrc_We);
        oFwdBranchRt = fwd_sel(iID_NumRt, iSrc_NumRd, iSrc_We);
    end

    // A register is pending while its counter is nonzero. Entry 0 is forced
    // clear so register 0 can never look busy. oBusy depends only on the
    // counter registers.
    always_comb begin
        pending = '0;
        for (int i = 1; i < NREG; i++) begin
            pending[i] = (lat_cnt[i] != '0);
        end
        oBusy = |pending;
    end

    // Each stall cause is evaluated on its own and the results are ORed
    // together. A WAW stall is only raised for an issue that would actually
    // be accepted otherwise. Issues to register 0 or with zero latency are
    // ignored entirely, so they never stall.
    always_comb begin
        load_use_stall = iEX_MemRead && (iEX_NumRd != '0) &&
                         ((iEX_NumRd == iID_NumRs) || (iEX_NumRd == iID_NumRt));
        branch_stall   = iID_Branch && iEX_RegWrite && (iEX_NumRd != '0) &&
                         ((iEX_NumRd == iID_NumRs) || (iEX_NumRd == iID_NumRt));
        raw_stall      = pending[iID_NumRs] || pending[iID_NumRt];
        waw_stall      = iIssue_Valid && (iIssue_Rd != '0) && (iIssue_Lat != '0) &&
                         pending[iIssue_Rd];
        oStall         = load_use_stall || branch_stall || raw_stall || waw_stall;
        issue_accept   = iIssue_Valid && !oStall && (iIssue_Rd != '0) && (iIssue_Lat != '0);
    end

    // Scoreboard counters. An accepted issue loads its register's counter
    // and takes precedence over that counter's decrement. Every other nonzero
    // counter counts down by one, so a counter stops at zero on its own and
    // never wraps.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NREG; i++) begin
                lat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue_accept && (iIssue_Rd == REGW'(i))) begin
                    lat_cnt[i] <= iIssue_Lat;
                end else if (lat_cnt[i] != '0) begin
                    lat_cnt[i] <= lat_cnt[i] - 1'b1;
                end
            end
        end
    end

`ifdef FWD_STALLCNT_EN
    logic [31:0] stall_cnt;

    // Counts every edge at which the pipeline is held. The count wraps
    // naturally at 2**32.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stall_cnt <= '0;
        end else if (oStall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign oStallCount = stall_cnt;
`else
    assign oStallCount = '0;
`endif

endmodule
